// File: rtl/chk_pkg.sv
// chk_pkg: event encodings and saturating arithmetic shared by the checker
package chk_pkg;
    localparam int CHK_MATCH     = 0;
    localparam int CHK_MISMATCH  = 1;
    localparam int CHK_UNDERFLOW = 2;
    localparam int CHK_OVERFLOW  = 3;
    localparam int CHK_EVENTS    = 4;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction
endpackage

// File: rtl/chk_fifo.sv
// chk_fifo: synchronous FIFO holding expected frames for one channel
module chk_fifo #(
    parameter int ADDR  = 2,
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [ADDR:0]    level
);
    logic [WIDTH-1:0] mem [2**ADDR];
    logic [ADDR:0] wptr, rptr;
    assign dout  = mem[rptr[ADDR-1:0]];
    assign level = wptr - rptr;
    assign empty = wptr == rptr;
    assign full  = level[ADDR];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (ADDR+1)'(push);
            rptr <= rptr + (ADDR+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wptr[ADDR-1:0]] <= din;
endmodule

// File: rtl/multi_chan_checker.sv
// multi_chan_checker: per-channel in-order expected/actual frame compare
// with sticky error flags, response timeouts and saturating totals
module multi_chan_checker
    import chk_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 256,
    parameter int ADDR     = 2,
    parameter int TIMEOUT  = 1024,
    parameter int CNTW     = 16
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          cmpMask,
    input  logic [CHANNELS-1:0]       expPush,
    input  logic [CHANNELS*WIDTH-1:0] expData,
    input  logic [CHANNELS-1:0]       actValid,
    input  logic [CHANNELS*WIDTH-1:0] actData,
    output logic [CHANNELS-1:0]       expEmpty,
    output logic [CHANNELS-1:0]       expFull,
    output logic [CHANNELS-1:0]       errFlag,
    output logic [CHANNELS-1:0]       timeoutFlag,
    output logic [CNTW-1:0]           matchCnt,
    output logic [CNTW-1:0]           mismatchCnt,
    output logic [CNTW-1:0]           underflowCnt,
    output logic                      testPass
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] CMAX = 32'((64'd1 << CNTW) - 64'd1);
    logic [CHANNELS-1:0] push, pop, empty, full, tmo_hit;
    logic [CHANNELS-1:0][WIDTH-1:0] head;
    logic [CHANNELS-1:0][ADDR:0] lvl;
    logic [CHK_EVENTS-1:0][CHANNELS-1:0] ev, ev_q;
    assign expEmpty = empty;
    assign expFull  = full;
    assign testPass = ~|errFlag;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [TW-1:0] tcnt;
        logic tick;
        logic diff;
        assign pop[c]  = actValid[c] & enable & ~empty[c];
        // a pop frees the slot before the write, so full+pop+push is legal
        assign push[c] = expPush[c] & enable & (~full[c] | pop[c]);
        assign diff    = |((head[c] ^ actData[c*WIDTH +: WIDTH]) & cmpMask);
        assign ev[CHK_MATCH][c]     = pop[c] & ~diff;
        assign ev[CHK_MISMATCH][c]  = pop[c] & diff;
        assign ev[CHK_UNDERFLOW][c] = actValid[c] & enable & empty[c];
        assign ev[CHK_OVERFLOW][c]  = expPush[c] & enable & full[c] & ~pop[c];
        chk_fifo #(.ADDR(ADDR), .WIDTH(WIDTH)) u_fifo (
            .clk(sclk), .rst(rst), .push(push[c]), .pop(pop[c]),
            .din(expData[c*WIDTH +: WIDTH]), .dout(head[c]),
            .empty(empty[c]), .full(full[c]), .level(lvl[c])
        );
        assign tick       = enable & ~pop[c] & |lvl[c] & (tcnt != TW'(TIMEOUT));
        assign tmo_hit[c] = tick & (tcnt == TW'(TIMEOUT - 1));
        always_ff @(posedge sclk or posedge rst)
            if (rst) tcnt <= '0;
            else if (clear || pop[c] || ~|lvl[c]) tcnt <= '0;
            else if (tick) tcnt <= tcnt + 1'b1;
    end
    // compare results are registered once, then folded into flags/counters
    always_ff @(posedge sclk or posedge rst)
        if (rst) begin
            ev_q         <= '0;
            errFlag      <= '0;
            timeoutFlag  <= '0;
            matchCnt     <= '0;
            mismatchCnt  <= '0;
            underflowCnt <= '0;
        end else begin
            ev_q <= ev;
            if (clear) begin
                errFlag      <= '0;
                timeoutFlag  <= '0;
                matchCnt     <= '0;
                mismatchCnt  <= '0;
                underflowCnt <= '0;
            end else begin
                errFlag      <= errFlag | ev_q[CHK_MISMATCH] | ev_q[CHK_UNDERFLOW] | ev_q[CHK_OVERFLOW] | tmo_hit;
                timeoutFlag  <= timeoutFlag | tmo_hit;
                matchCnt     <= CNTW'(sat_add(32'(matchCnt), 32'($countones(ev_q[CHK_MATCH])), CMAX));
                mismatchCnt  <= CNTW'(sat_add(32'(mismatchCnt), 32'($countones(ev_q[CHK_MISMATCH])), CMAX));
                underflowCnt <= CNTW'(sat_add(32'(underflowCnt), 32'($countones(ev_q[CHK_UNDERFLOW])), CMAX));
            end
        end
endmodule

// File: doc/multi_chan_checker.md
Name: multi_chan_checker

Overview:
- Parametrised, multi-channel successor to the single-stream checker/scoreboard pair used on the serial (sclk) side of the AudioNet bench.
- Each channel buffers expected frames in its own FIFO and compares them in order against actual frames from a monitor, using a global compare mask.
- Flags underflow, overflow and response timeout per channel, and keeps aggregate match/mismatch counters.
- Sits between the rectifier/regmon monitors and the bench's pass/fail reporting.

Parameters:
CHANNELS, 4, number of independent compare channels
WIDTH, 256, frame width in bits
ADDR, 2, log2 of per-channel expected-FIFO depth (depth = 2^ADDR)
TIMEOUT, 1024, sclk cycles a non-empty FIFO may wait for an actual frame
CNTW, 16, width of the aggregate counters

Ports:
sclk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
enable  in  1  when low, pushes and actValid are ignored and timeout counters hold
clear  in  1  synchronous clear of counters and sticky flags; FIFO contents are kept
cmpMask  in  WIDTH  1 = bit compared, 0 = don't-care; applies to all channels
expPush  in  CHANNELS  per-channel expected-frame push strobe
expData  in  CHANNELS*WIDTH  expected frames; channel c occupies bits [c*WIDTH +: WIDTH]
actValid  in  CHANNELS  per-channel actual-frame strobe
actData  in  CHANNELS*WIDTH  actual frames, same packing as expData
expEmpty  out  CHANNELS  FIFO empty per channel
expFull  out  CHANNELS  FIFO full per channel
errFlag  out  CHANNELS  sticky: any mismatch, underflow, overflow or timeout on that channel
timeoutFlag  out  CHANNELS  sticky timeout per channel
matchCnt  out  CNTW  total matched frames, saturating
mismatchCnt  out  CNTW  total mismatched frames, saturating
underflowCnt  out  CNTW  total actual frames arriving with an empty FIFO, saturating
testPass  out  1  ~|errFlag

Behaviour:
- Reset values:
  - All FIFOs empty: expEmpty all 1, expFull all 0.
  - All counters 0; errFlag and timeoutFlag all 0; testPass 1.
- Push: expPush[c] & enable & !expFull[c] writes the frame.
  - Push while full is dropped and sets errFlag[c] (overflow).
  - Push while full and pop in the same cycle is accepted: pop first, then write; occupancy is unchanged.
- Compare: actValid[c] & enable & !expEmpty[c] pops the head frame.
  - Match condition: ((head ^ act) & cmpMask) == 0.
  - Result is registered; counters and errFlag update one cycle after actValid.
- Underflow: actValid[c] while expEmpty[c] increments underflowCnt and sets errFlag[c].
  - No bypass: a push in the same cycle does not satisfy the actual frame; the pushed frame is still stored.
- Multiple channels in one cycle: each counter adds the popcount of qualifying channels.
  - Counters saturate at 2^CNTW-1 and never wrap.
- Timeout: per-channel counter of ceil(log2(TIMEOUT+1)) bits.
  - Increments while the FIFO is non-empty, enable is high and there is no pop.
  - Clears on pop or when the FIFO is empty.
  - On reaching TIMEOUT: sets timeoutFlag[c] and errFlag[c], then holds at TIMEOUT (no retrigger).
- clear: counters, errFlags, timeoutFlags and timeout counters go to 0 on the next edge.
  - clear has priority over a same-cycle increment or flag set.
- FIFO pointers are ADDR+1 bits; the MSB distinguishes full from empty; wrap is natural modulo 2^ADDR.
- rst asserted mid-operation returns every state to its reset value asynchronously; in-flight compares are discarded.

Decomposition:
- Shared package chk_pkg:
  - Result-encoding constants: CHK_MATCH, CHK_MISMATCH, CHK_UNDERFLOW, CHK_OVERFLOW.
  - Saturating-add function.
- One sub-module chk_fifo (ADDR, WIDTH): synchronous FIFO with push, pop, dout, empty, full and level. It is instantiated CHANNELS times in a generate loop.
- Compare, timeout and counter logic lives in the top level.

Test Plan:
- Ordered match: ch0 push A5A5..A5 then 3C3C..3C; actual A5.., 3C.. on later cycles -> matchCnt=2, errFlag=0, testPass=1.
- Masked compare: cmpMask=all 1 except bit0=0; exp=...00, act=...01 -> matchCnt=1, mismatchCnt=0. Repeat with bit0 in the mask -> mismatchCnt=1, errFlag[0]=1, testPass=0.
- Underflow and overflow (ADDR=2):
  - actValid[1] on an empty FIFO -> underflowCnt=1, errFlag[1]=1.
  - 5 pushes to ch2 -> expFull[2]=1 after the 4th push; the 5th is dropped; errFlag[2]=1; exactly 4 pops available.
- Timeout: TIMEOUT=8, one push on ch3, no actual -> timeoutFlag[3]=1 exactly 8 cycles after the push lands. clear -> flag 0; it re-asserts 8 cycles later (frame still queued).
- Concurrency and saturation: CNTW=3; all 4 channels match in the same cycle twice -> matchCnt=7, held at 7. Simultaneous push+pop on a full FIFO -> level stays 4, no overflow.
- Reset mid-operation: assert rst with 2 frames queued on ch0 -> expEmpty=all 1, counters 0, testPass=1 while rst is high and after release.
